mem_arbiter: RTL and testbench

Two-requester arbiter that shares one external memory port between the instruction-fetch path and the data-memory path of the five-stage pipeline. It sits between the core and the single-ported SRAM bus. It sequences one transaction at a time with a req/ack handshake, alternates grants when both requesters contend, aborts transactions that exceed a timeout, and drives per-requester stall requests toward the pipeline stall controller.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one SRAM port between fetch and data requesters, one transaction at a time.
// Latency: grant -> mem_req next cycle; mem ack -> requester ack next cycle; timeout after TIMEOUT cycles.
// Backpressure: requesters hold req until ack; stall requests stay high until the owner's ack cycle.
module mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_sel_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        err_o,
    output logic        stallreq_if_o,
    output logic        stallreq_dm_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic          OWN_IF  = 1'b0;
    localparam logic          OWN_DM  = 1'b1;
    localparam logic [TW-1:0] CNT_END = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_sel_q, mem_sel_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          grant_dm;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        // On a tie the requester that did not win last time gets the port.
        grant_dm    = dm_req_i && (!if_req_i || last_q == OWN_IF);

        case (state_q)
            IDLE: begin
                if (if_req_i || dm_req_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (grant_dm) begin
                        owner_d     = OWN_DM;
                        last_d      = OWN_DM;
                        mem_we_d    = dm_we_i;
                        mem_sel_d   = dm_sel_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                    end else begin
                        owner_d     = OWN_IF;
                        last_d      = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_sel_d   = 4'hF;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    if (owner_q == OWN_DM) dm_rdata_d = mem_rdata_i;
                    else                   if_rdata_d = mem_rdata_i;
                end else if (cnt_q == CNT_END) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_DM) dm_rdata_d = '0;
                    else                   if_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // Request is decoded from state so an async reset drops it at once.
    assign mem_req_o     = (state_q == BUSY);
    assign mem_we_o      = mem_we_q;
    assign mem_sel_o     = mem_sel_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign if_rdata_o    = if_rdata_q;
    assign dm_rdata_o    = dm_rdata_q;
    assign if_ack_o      = (state_q == DONE) && (owner_q == OWN_IF);
    assign dm_ack_o      = (state_q == DONE) && (owner_q == OWN_DM);
    assign err_o         = (state_q == DONE) && err_q;
    assign stallreq_if_o = if_req_i && !if_ack_o;
    assign stallreq_dm_o = dm_req_i && !dm_ack_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions, decoupled memory-side and requester-side monitors.
module tb_mem_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        err_o;
    logic        stallreq_if_o;
    logic        stallreq_dm_o;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .err_o(err_o), .stallreq_if_o(stallreq_if_o), .stallreq_dm_o(stallreq_dm_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  sel;
        int          len;   // expected mem_req_o high cycles, 0 = not checked
    } mexp_t;

    typedef struct {
        bit          is_dm;
        logic [31:0] rdata;
        bit          err;
    } aexp_t;

    mexp_t mq[$];
    aexp_t aq[$];

    int total = 0;
    int bad   = 0;

    // Memory model knobs
    int          waits_v   = 0;
    bit          ackon_v   = 1'b1;
    logic [31:0] key_v     = '0;
    bit          force_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Memory responder and memory-side monitor
    initial begin
        int    busy_cnt;
        bit    prev_req;
        bit    have_cur;
        mexp_t cur;
        busy_cnt    = 0;
        prev_req    = 1'b0;
        have_cur    = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '1;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                busy_cnt++;
                if (busy_cnt == 1) begin
                    if (mq.size() == 0) begin
                        flag("unexpected_mem_req");
                        have_cur = 1'b0;
                    end else begin
                        cur      = mq.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    chk("mem_addr", mem_addr_o, cur.addr);
                    chk("mem_we", 32'(mem_we_o), 32'(cur.we));
                    chk("mem_sel", 32'(mem_sel_o), 32'(cur.sel));
                    chk("mem_wdata", mem_wdata_o, cur.wdata);
                end
            end else if (prev_req) begin
                if (have_cur && cur.len != 0)
                    chk("mem_req_len", 32'(busy_cnt), 32'(cur.len));
                busy_cnt = 0;
                have_cur = 1'b0;
            end
            prev_req = mem_req_o;
            if ((mem_req_o && ackon_v && busy_cnt == waits_v + 1) || force_ack) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_addr_o ^ key_v;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = '1;
            end
        end
    end

    task automatic check_ack(input bit is_dm, input logic [31:0] rdata);
        aexp_t e;
        if (aq.size() == 0) begin
            flag(is_dm ? "unexpected_dm_ack" : "unexpected_if_ack");
        end else begin
            e = aq.pop_front();
            chk("ack_owner", 32'(is_dm), 32'(e.is_dm));
            chk("ack_rdata", rdata, e.rdata);
            chk("ack_err", 32'(err_o), 32'(e.err));
        end
    endtask

    // Requester-side monitor
    initial begin
        forever begin
            @(negedge clk);
            if (if_ack_o && dm_ack_o) flag("both_acks");
            if (if_ack_o) check_ack(1'b0, if_rdata_o);
            if (dm_ack_o) check_ack(1'b1, dm_rdata_o);
            if (err_o && !if_ack_o && !dm_ack_o) flag("err_without_ack");
        end
    end

    task automatic push_exp(input bit is_dm, input logic we, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata, input int len,
                            input logic [31:0] exp_rdata, input bit exp_err, input bit want_ack);
        mexp_t m;
        aexp_t a;
        m.addr  = addr;
        m.we    = is_dm ? we : 1'b0;
        m.sel   = is_dm ? sel : 4'hF;
        m.wdata = is_dm ? wdata : 32'h0;
        m.len   = len;
        mq.push_back(m);
        if (want_ack) begin
            a.is_dm = is_dm;
            a.rdata = exp_rdata;
            a.err   = exp_err;
            aq.push_back(a);
        end
    endtask

    task automatic single_txn(input bit is_dm, input logic we, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int waits, input bit ackon, input logic [31:0] key,
                              input logic [31:0] exp_rdata, input bit exp_err, input int exp_len);
        int   exp_done;
        int   got;
        logic stall;
        logic ack;
        waits_v  = waits;
        ackon_v  = ackon;
        key_v    = key;
        push_exp(is_dm, we, sel, addr, wdata, exp_len, exp_rdata, exp_err, 1'b1);
        exp_done = ackon ? waits + 2 : TIMEOUT + 1;
        @(posedge clk); #1;
        if (is_dm) begin
            dm_we_i = we; dm_sel_i = sel; dm_addr_i = addr; dm_wdata_i = wdata; dm_req_i = 1'b1;
        end else begin
            if_addr_i = addr; if_req_i = 1'b1;
        end
        got = -1;
        for (int i = 0; i < exp_done + 4; i++) begin
            @(negedge clk);
            stall = is_dm ? stallreq_dm_o : stallreq_if_o;
            ack   = is_dm ? dm_ack_o : if_ack_o;
            chk("stallreq", 32'(stall), 32'(i != exp_done));
            if (ack) begin
                got = i;
                break;
            end
        end
        chk("ack_latency", 32'(got), 32'(exp_done));
        @(posedge clk); #1;
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int ni;
        int nd;
        rst = 1'b1;
        if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0;
        dm_sel_i = 0; dm_addr_i = 0; dm_wdata_i = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req_o), 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_we", 32'(mem_we_o), 32'h0);
        chk("rst_mem_sel", 32'(mem_sel_o), 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_acks", {30'h0, if_ack_o, dm_ack_o}, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_if_rdata", if_rdata_o, 32'h0);
        chk("rst_dm_rdata", dm_rdata_o, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Contention straight out of reset: DM, IF, DM, IF
        waits_v = 0; ackon_v = 1'b1; key_v = 32'h0F0F_0000;
        push_exp(1'b1, 1'b0, 4'hC, 32'h2000, 32'h1111_2222, 1, 32'h0F0F_2000, 1'b0, 1'b1);
        push_exp(1'b0, 1'b0, 4'hF, 32'h1000, 32'h0,        1, 32'h0F0F_1000, 1'b0, 1'b1);
        push_exp(1'b1, 1'b0, 4'hC, 32'h2000, 32'h1111_2222, 1, 32'h0F0F_2000, 1'b0, 1'b1);
        push_exp(1'b0, 1'b0, 4'hF, 32'h1000, 32'h0,        1, 32'h0F0F_1000, 1'b0, 1'b1);
        @(posedge clk); #1;
        if_addr_i = 32'h1000; dm_addr_i = 32'h2000; dm_we_i = 0; dm_sel_i = 4'hC;
        dm_wdata_i = 32'h1111_2222; if_req_i = 1; dm_req_i = 1;
        ni = 0; nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if_ack_o) ni++;
            if (dm_ack_o) nd++;
            @(posedge clk); #1;
            if (nd == 2) dm_req_i = 0;
            if (ni == 2) if_req_i = 0;
            if (ni == 2 && nd == 2) break;
        end
        chk("contention_if_acks", 32'(ni), 32'd2);
        chk("contention_dm_acks", 32'(nd), 32'd2);
        @(posedge clk); #1;

        // Fetch, zero wait
        single_txn(1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 0, 1'b1, 32'h3401_1000,
                   32'h3401_1100, 1'b0, 1);
        // Data write, 3 wait states
        single_txn(1'b1, 1'b1, 4'b0011, 32'h80, 32'hDEAD_BEEF, 3, 1'b1, 32'h0,
                   32'h0000_0080, 1'b0, 4);
        // Timeout with no memory ack
        single_txn(1'b1, 1'b0, 4'hF, 32'h44, 32'h0, 0, 1'b0, 32'h0,
                   32'h0, 1'b1, TIMEOUT);
        // Ack on the final allowed cycle beats the timeout
        single_txn(1'b1, 1'b0, 4'hF, 32'h40, 32'h0, TIMEOUT - 1, 1'b1, 32'h45,
                   32'h0000_0005, 1'b0, TIMEOUT);

        // Reset in the middle of a fetch
        ackon_v = 1'b0;
        push_exp(1'b0, 1'b0, 4'hF, 32'h300, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1 if_addr_i = 32'h300; if_req_i = 1;
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req_o), 32'h0);
        chk("rst_mid_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mid_if_rdata", if_rdata_o, 32'h0);
        if_req_i = 0;
        @(posedge clk); #1 rst = 1'b0; force_ack = 1'b1;
        @(posedge clk); #1 force_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_mem_req", 32'(mem_req_o), 32'h0);
            chk("post_rst_if_rdata", if_rdata_o, 32'h0);
        end

        // Normal fetch after reset
        single_txn(1'b0, 1'b0, 4'h0, 32'h200, 32'h0, 1, 1'b1, 32'hAB00_0000,
                   32'hAB00_0200, 1'b0, 2);

        repeat (3) @(negedge clk);
        chk("ack_queue_drained", 32'(aq.size()), 32'h0);
        chk("mem_queue_drained", 32'(mq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
